// File: rtl/score_keeper.sv
// Pong match controller: turns point edges into two binary scores and
// sequences serve delay, win-by-two, game-over hold and restart.
module score_keeper #(
  parameter int WIN_SCORE   = 11,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        point_p1,
  input  logic        point_p2,
  input  logic        new_game,
  output logic [15:0] displayNumber1,
  output logic [15:0] displayNumber2,
  output logic        serve_en,
  output logic        serve_dir,
  output logic        game_over,
  output logic        winner
);

  localparam int              CW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]   RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [16:0]     WIN17  = 17'(WIN_SCORE);
  localparam logic [15:0]     SAT    = 16'd9999;

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] s1_q, s1_d, s2_q, s2_d;
  logic        dir_q, dir_d, en_q, en_d, over_q, over_d, win_q, win_d;
  logic        p1_prev_q, p2_prev_q, ng_prev_q;
  logic        p1_ev, p2_ev, ng_ev;
  logic [15:0] s1_inc, s2_inc;
  logic        p1_win, p2_win;

  assign p1_ev = point_p1 & ~p1_prev_q;
  assign p2_ev = point_p2 & ~p2_prev_q;
  assign ng_ev = new_game & ~ng_prev_q;

  assign s1_inc = (s1_q >= SAT) ? SAT : s1_q + 16'd1;
  assign s2_inc = (s2_q >= SAT) ? SAT : s2_q + 16'd1;

  // 17-bit compare so the +2 margin cannot wrap near saturation
  assign p1_win = ({1'b0, s1_inc} >= WIN17) && ({1'b0, s1_inc} >= {1'b0, s2_q} + 17'd2);
  assign p2_win = ({1'b0, s2_inc} >= WIN17) && ({1'b0, s2_inc} >= {1'b0, s1_q} + 17'd2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dir_d   = dir_q;
    win_d   = win_q;
    if (ng_ev) begin
      state_d = SERVE;
      cnt_d   = RELOAD;
      s1_d    = '0;
      s2_d    = '0;
      dir_d   = 1'b0;
    end else begin
      case (state_q)
        SERVE: begin
          if (cnt_q == '0) state_d = PLAY;
          else             cnt_d   = cnt_q - 1'b1;
        end
        PLAY: begin
          if (p1_ev && !p2_ev) begin
            s1_d  = s1_inc;
            dir_d = 1'b1;
            if (p1_win) begin
              state_d = OVER;
              win_d   = 1'b0;
            end else begin
              state_d = SERVE;
              cnt_d   = RELOAD;
            end
          end else if (p2_ev && !p1_ev) begin
            s2_d  = s2_inc;
            dir_d = 1'b0;
            if (p2_win) begin
              state_d = OVER;
              win_d   = 1'b1;
            end else begin
              state_d = SERVE;
              cnt_d   = RELOAD;
            end
          end
        end
        default: ;
      endcase
    end
    en_d   = (state_d == PLAY);
    over_d = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      dir_q     <= 1'b0;
      en_q      <= 1'b0;
      over_q    <= 1'b0;
      win_q     <= 1'b0;
      p1_prev_q <= 1'b0;
      p2_prev_q <= 1'b0;
      ng_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      dir_q     <= dir_d;
      en_q      <= en_d;
      over_q    <= over_d;
      win_q     <= win_d;
      p1_prev_q <= point_p1;
      p2_prev_q <= point_p2;
      ng_prev_q <= new_game;
    end
  end

  assign displayNumber1 = s1_q;
  assign displayNumber2 = s2_q;
  assign serve_en       = en_q;
  assign serve_dir      = dir_q;
  assign game_over      = over_q;
  assign winner         = win_q;

endmodule
